// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int         DATA_W              = 32;
  localparam logic [3:0] STRB_FULL           = 4'hF;
  localparam int         DEFAULT_DEPTH_WORDS = 2048;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Byte-lane merge: take the new lane where the strobe is set, keep the old lane otherwise.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] new_word,
    input logic [DATA_W-1:0] old_word,
    input logic [3:0]        strb
  );
    logic [DATA_W-1:0] res;
    for (int k = 0; k < 4; k++) begin
      res[k*8 +: 8] = strb[k] ? new_word[k*8 +: 8] : old_word[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after the pointer wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  int   idx;
  logic found;

  // Rotating priority search starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(i_ptr) + i) % NUM_REQ;
      if (!found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer in front of a single-port word memory; sub-word stores run as
// read-modify-write. Optional address checking is enabled with DMEM_ARBITER_BOUNDS_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ-1:0]      i_req_we,
  input  logic [32*NUM_REQ-1:0]   i_req_addr,
  input  logic [32*NUM_REQ-1:0]   i_req_wdata,
  input  logic [4*NUM_REQ-1:0]    i_req_wstrb,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  output logic [DATA_W-1:0]       o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic [31:0]             o_mem_addr,
  output logic [DATA_W-1:0]       o_mem_wdata,
  output logic                    o_mem_wren,
  input  logic [DATA_W-1:0]       i_mem_rdata
);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [31:0]        addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [DATA_W-1:0]  merge_q, merge_d;
  logic               err_q, err_d;
  logic               addr_bad;
  logic [NUM_REQ-1:0] grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant)
  );

`ifdef DMEM_ARBITER_BOUNDS_EN
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);
  // Misaligned or past-the-end accesses never reach the memory.
  always_comb addr_bad = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH_LIM);
`else
  logic unused_depth;
  assign unused_depth = ^DEPTH_WORDS;
  // Without the check every address is forwarded as-is.
  always_comb addr_bad = 1'b0;
`endif

  // Sequencing, payload capture and memory/response drive.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    merge_d     = merge_q;
    err_d       = err_q;
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_rsp_rdata = '0;
    o_rsp_err   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wren  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is suppressed while reset is held so every output reads 0.
        o_req_ready = i_reset ? '0 : grant;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant[i]) begin
            owner_d = PTR_W'(i);
            addr_d  = i_req_addr[i*32 +: 32];
            wdata_d = i_req_wdata[i*32 +: 32];
            wstrb_d = i_req_wstrb[i*4 +: 4];
            we_d    = i_req_we[i];
          end
        end
        if (|grant) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        state_d = RESP;
        if (addr_bad) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          o_mem_addr = addr_q;
          if (!we_q) begin
            rdata_d = i_mem_rdata;
          end else if (wstrb_q == STRB_FULL) begin
            o_mem_wdata = wdata_q;
            o_mem_wren  = 1'b1;
          end else if (wstrb_q != 4'h0) begin
            merge_d = i_mem_rdata;
            state_d = MERGE;
          end
        end
      end

      MERGE: begin
        o_mem_addr  = addr_q;
        o_mem_wdata = merge_bytes(wdata_q, merge_q, wstrb_q);
        o_mem_wren  = 1'b1;
        state_d     = RESP;
      end

      RESP: begin
        o_rsp_valid[owner_q] = 1'b1;
        o_rsp_rdata          = we_q ? '0 : rdata_q;
        o_rsp_err            = err_q;
        ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and payload registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural word memory.
module tb_dmem_arbiter;

  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_we;
  logic [63:0]   req_addr;
  logic [63:0]   req_wdata;
  logic [7:0]    req_wstrb;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_wren;
  logic [31:0]   mem_rdata;

  logic [31:0] mem [0:2047];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          hs;
    int          rsp_cyc;
    int          rsp_cnt;
    int          wren_cyc;
    int          wren_cnt;
    int          addr_nz;
    logic [31:0] wr_word;
    logic [31:0] rdata;
    logic        err;
  } res_t;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_REQ(NR), .DEPTH_WORDS(2048)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_wstrb (req_wstrb),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_wren  (mem_wren),
    .i_mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[12:2]];

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr[12:2]] <= mem_wdata;
  end

  // Drive one transaction from requester req; cycle 0 is the handshake cycle.
  task automatic run_txn(input int req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, output res_t r);
    r.hs = 0; r.rsp_cyc = -1; r.rsp_cnt = 0; r.wren_cyc = -1; r.wren_cnt = 0;
    r.addr_nz = 0; r.wr_word = '0; r.rdata = '0; r.err = 1'b0;
    @(posedge clk); #1;
    req_valid[req]          = 1'b1;
    req_we[req]             = we;
    req_addr[req*32 +: 32]  = addr;
    req_wdata[req*32 +: 32] = wdata;
    req_wstrb[req*4 +: 4]   = strb;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[req]) begin
        r.hs = 1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[req] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (mem_addr != 32'h0) r.addr_nz++;
      if (mem_wren) begin
        r.wren_cnt++;
        if (r.wren_cyc < 0) begin
          r.wren_cyc = c;
          r.wr_word  = mem_wdata;
        end
      end
      if (rsp_valid[req]) begin
        r.rsp_cnt++;
        if (r.rsp_cyc < 0) begin
          r.rsp_cyc = c;
          r.rdata   = rsp_rdata;
          r.err     = rsp_err;
        end
      end
    end
    $display("txn req=%0d we=%0d addr=%h wdata=%h strb=%h -> rsp_cyc=%0d rdata=%h err=%0d wren_cyc=%0d",
             req, we, addr, wdata, strb, r.rsp_cyc, r.rdata, r.err, r.wren_cyc);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rst_mem_wren: got %b expected 0", mem_wren); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_grant: got %b expected 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rst_first_rsp: got %b expected 01", rsp_valid); end
    $display("txn reset then first grant to req0");
    @(negedge clk);
  endtask

  task automatic test_full_write_read();
    res_t r;
    run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r);
    checks++; if (r.hs !== 1) begin errors++; $display("FAIL fw_handshake: got %0d expected 1", r.hs); end
    checks++; if (r.wren_cyc !== 1) begin errors++; $display("FAIL fw_wren_cyc: got %0d expected 1", r.wren_cyc); end
    checks++; if (r.wren_cnt !== 1) begin errors++; $display("FAIL fw_wren_cnt: got %0d expected 1", r.wren_cnt); end
    checks++; if (r.wr_word !== 32'hDEADBEEF) begin errors++; $display("FAIL fw_wdata: got %h expected deadbeef", r.wr_word); end
    checks++; if (r.rsp_cyc !== 2) begin errors++; $display("FAIL fw_rsp_cyc: got %0d expected 2", r.rsp_cyc); end
    checks++; if (r.rsp_cnt !== 1) begin errors++; $display("FAIL fw_rsp_cnt: got %0d expected 1", r.rsp_cnt); end
    checks++; if (r.rdata !== 32'h0) begin errors++; $display("FAIL fw_rsp_rdata: got %h expected 0", r.rdata); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL fw_mem: got %h expected deadbeef", mem[4]); end
    run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, r);
    checks++; if (r.rsp_cyc !== 2) begin errors++; $display("FAIL rd_rsp_cyc: got %0d expected 2", r.rsp_cyc); end
    checks++; if (r.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h expected deadbeef", r.rdata); end
    checks++; if (r.wren_cnt !== 0) begin errors++; $display("FAIL rd_wren_cnt: got %0d expected 0", r.wren_cnt); end
  endtask

  task automatic test_partial_rmw();
    res_t r;
    mem[8] = 32'h11223344;
    run_txn(0, 1'b1, 32'h20, 32'h000000AA, 4'h1, r);
    checks++; if (r.wren_cyc !== 2) begin errors++; $display("FAIL rmw_wren_cyc: got %0d expected 2", r.wren_cyc); end
    checks++; if (r.wren_cnt !== 1) begin errors++; $display("FAIL rmw_wren_cnt: got %0d expected 1", r.wren_cnt); end
    checks++; if (r.wr_word !== 32'h112233AA) begin errors++; $display("FAIL rmw_wdata: got %h expected 112233aa", r.wr_word); end
    checks++; if (r.rsp_cyc !== 3) begin errors++; $display("FAIL rmw_rsp_cyc: got %0d expected 3", r.rsp_cyc); end
    checks++; if (mem[8] !== 32'h112233AA) begin errors++; $display("FAIL rmw_mem: got %h expected 112233aa", mem[8]); end
    mem[9] = 32'h11223344;
    run_txn(1, 1'b1, 32'h24, 32'hAABBCCDD, 4'hA, r);
    checks++; if (r.rsp_cyc !== 3) begin errors++; $display("FAIL rmw2_rsp_cyc: got %0d expected 3", r.rsp_cyc); end
    checks++; if (mem[9] !== 32'hAA22CC44) begin errors++; $display("FAIL rmw2_mem: got %h expected aa22cc44", mem[9]); end
  endtask

  task automatic test_zero_strobe();
    res_t r;
    run_txn(0, 1'b1, 32'h10, 32'h0BADF00D, 4'h0, r);
    checks++; if (r.wren_cnt !== 0) begin errors++; $display("FAIL zs_wren_cnt: got %0d expected 0", r.wren_cnt); end
    checks++; if (r.rsp_cyc !== 2) begin errors++; $display("FAIL zs_rsp_cyc: got %0d expected 2", r.rsp_cyc); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL zs_mem: got %h expected deadbeef", mem[4]); end
  endtask

  task automatic test_reset_mid_rmw();
    int hs;
    int wren_cnt;
    int rsp_cnt;
    logic wren_merge;
    mem[12] = 32'h11223344;
    hs = 0; wren_cnt = 0; rsp_cnt = 0;
    @(posedge clk); #1;
    req_valid[0]       = 1'b1;
    req_we[0]          = 1'b1;
    req_addr[31:0]     = 32'h30;
    req_wdata[31:0]    = 32'h0000BB00;
    req_wstrb[3:0]     = 4'h2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        hs = 1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wren_merge = mem_wren;
    checks++; if (hs !== 1 || wren_merge !== 1'b1) begin errors++; $display("FAIL mr_in_merge: got hs=%0d wren=%b expected hs=1 wren=1", hs, wren_merge); end
    rst = 1'b1;
    #1;
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL mr_wren_on_reset: got %b expected 0", mem_wren); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_wren) wren_cnt++;
      if (rsp_valid != 2'b00) rsp_cnt++;
    end
    checks++; if (wren_cnt !== 0) begin errors++; $display("FAIL mr_wren_after: got %0d expected 0", wren_cnt); end
    checks++; if (rsp_cnt !== 0) begin errors++; $display("FAIL mr_rsp_after: got %0d expected 0", rsp_cnt); end
    checks++; if (mem[12] !== 32'h11223344) begin errors++; $display("FAIL mr_mem: got %h expected 11223344", mem[12]); end
    $display("txn reset during merge, addr=00000030");
  endtask

  task automatic test_contention();
    int order [4];
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    @(posedge clk); #1;
    req_we    = 2'b00;
    req_addr  = {32'h20, 32'h10};
    req_valid = 2'b11;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (req_ready == 2'b01) begin order[n] = 0; n++; end
      else if (req_ready == 2'b10) begin order[n] = 1; n++; end
      else if (req_ready != 2'b00) begin order[n] = 9; n++; end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    checks++; if (n !== 4) begin errors++; $display("FAIL ct_grant_count: got %0d expected 4", n); end
    checks++; if (order[0] !== 0) begin errors++; $display("FAIL ct_grant0: got %0d expected 0", order[0]); end
    checks++; if (order[1] !== 1) begin errors++; $display("FAIL ct_grant1: got %0d expected 1", order[1]); end
    checks++; if (order[2] !== 0) begin errors++; $display("FAIL ct_grant2: got %0d expected 0", order[2]); end
    checks++; if (order[3] !== 1) begin errors++; $display("FAIL ct_grant3: got %0d expected 1", order[3]); end
    $display("txn contention grants %0d %0d %0d %0d", order[0], order[1], order[2], order[3]);
  endtask

`ifdef DMEM_ARBITER_BOUNDS_EN
  task automatic test_bounds();
    res_t r;
    mem[2047] = 32'hCAFEF00D;
    run_txn(0, 1'b0, 32'h2002, 32'h0, 4'h0, r);
    checks++; if (r.err !== 1'b1) begin errors++; $display("FAIL bd_misalign_err: got %b expected 1", r.err); end
    checks++; if (r.rdata !== 32'h0) begin errors++; $display("FAIL bd_misalign_rdata: got %h expected 0", r.rdata); end
    checks++; if (r.addr_nz !== 0 || r.wren_cnt !== 0) begin errors++; $display("FAIL bd_misalign_access: got addr_nz=%0d wren=%0d expected 0 0", r.addr_nz, r.wren_cnt); end
    checks++; if (r.rsp_cyc !== 2) begin errors++; $display("FAIL bd_misalign_rsp_cyc: got %0d expected 2", r.rsp_cyc); end
    run_txn(1, 1'b0, 32'h2000, 32'h0, 4'h0, r);
    checks++; if (r.err !== 1'b1) begin errors++; $display("FAIL bd_depth_err: got %b expected 1", r.err); end
    run_txn(0, 1'b0, 32'h1FFC, 32'h0, 4'h0, r);
    checks++; if (r.err !== 1'b0) begin errors++; $display("FAIL bd_last_err: got %b expected 0", r.err); end
    checks++; if (r.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL bd_last_rdata: got %h expected cafef00d", r.rdata); end
  endtask
`else
  task automatic test_unaligned();
    res_t r;
    run_txn(1, 1'b0, 32'h13, 32'h0, 4'h0, r);
    checks++; if (r.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ua_rdata: got %h expected deadbeef", r.rdata); end
    checks++; if (r.err !== 1'b0) begin errors++; $display("FAIL ua_err: got %b expected 0", r.err); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    test_reset();
    test_full_write_read();
    test_partial_rmw();
    test_zero_strobe();
`ifdef DMEM_ARBITER_BOUNDS_EN
    test_bounds();
`else
    test_unaligned();
`endif
    test_reset_mid_rmw();
    test_contention();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequencer and arbiter in front of the single-port, word-wide data memory.
- Shares the memory between NUM_REQ requesters, for example core LSU (req 0) and debug/loader port (req 1), using round-robin arbitration with a valid/ready request handshake.
- The memory writes whole words only, so sub-word stores with a partial byte strobe run as a read-modify-write sequence.
- Returns a single-cycle response pulse to the requester that owns the transaction.

Parameters:
- NUM_REQ, 2: number of requesters (≥2).
- DEPTH_WORDS, 2048: memory depth in 32-bit words. Used only by the optional bounds check.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_req_valid  in  NUM_REQ  request valid, one bit per requester
- i_req_we  in  NUM_REQ  1 = write, 0 = read
- i_req_addr  in  32*NUM_REQ  byte address; requester n uses bits [32n+31:32n]
- i_req_wdata  in  32*NUM_REQ  write data
- i_req_wstrb  in  4*NUM_REQ  byte strobes; bit k enables byte lane k
- o_req_ready  out  NUM_REQ  request accepted this cycle
- o_rsp_valid  out  NUM_REQ  one-cycle response pulse
- o_rsp_rdata  out  32  read data; shared bus, qualified by o_rsp_valid
- o_rsp_err  out  1  error flag, qualified by o_rsp_valid
- o_mem_addr  out  32  memory byte address
- o_mem_wdata  out  32  memory write data
- o_mem_wren  out  1  memory write enable
- i_mem_rdata  in  32  memory read data (combinational from o_mem_addr)

Behaviour:
- Reset (async, active-high): state = IDLE, rr pointer = 0. All outputs read 0.
- Reset mid-operation: the transaction is abandoned. No memory write and no response are issued.
- FSM states: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - Arbitration is combinational. Search starts at the rr pointer and picks the first requester with valid high.
  - o_req_ready is high for the winner only. The handshake completes that cycle.
  - On handshake, latch owner, addr, wdata, wstrb, we; next state is ACCESS.
  - With no request, stay in IDLE.
- Requesters hold valid and payload stable until they see ready.
- ACCESS: o_mem_addr = latched addr.
  - Read: capture i_mem_rdata into the response register, then go to RESP.
  - Write, wstrb == 4'hF: o_mem_wdata = wdata, o_mem_wren = 1, then go to RESP.
  - Write, wstrb == 4'h0: no write, then go to RESP.
  - Write, partial strobe: capture i_mem_rdata into the merge register, then go to MERGE.
- MERGE:
  - Each byte lane k = wdata lane k if wstrb[k] is set, else the merge-register lane.
  - o_mem_addr = latched addr, o_mem_wren = 1, then go to RESP.
- RESP:
  - o_rsp_valid[owner] = 1 for exactly one cycle.
  - o_rsp_rdata = captured word for reads, 0 for writes.
  - rr pointer = (owner+1) mod NUM_REQ; next state is IDLE.
- Latency, counted from the handshake cycle (cycle 0) to the response pulse:
  - read: cycle 2
  - full or zero-strobe write: cycle 2
  - partial write: cycle 3
- Outside ACCESS and MERGE: o_mem_addr = 0, o_mem_wdata = 0, o_mem_wren = 0.
- Throughput: at most one transaction in flight. No ready is given in ACCESS, MERGE or RESP.
- Simultaneous requests: the rr pointer decides the winner. The loser stays pending and wins the next IDLE.
- Pointer wraps modulo NUM_REQ.
- addr[1:0] is ignored for word selection; the memory indexes on addr[31:2].
- No response backpressure: the requester must accept the pulse.

Optional Feature:
- Macro: DMEM_ARBITER_BOUNDS_EN.
- Defined:
  - In ACCESS, an error is flagged if addr[1:0] != 0, or if addr[31:2] >= DEPTH_WORDS.
  - On error: no memory read or write, o_mem_wren stays 0, go directly to RESP with o_rsp_err = 1 and o_rsp_rdata = 0.
- Not defined: o_rsp_err is tied to 0 and no address checks are performed.

Decomposition:
- Package dmem_arbiter_pkg holds:
  - state enum (IDLE, ACCESS, MERGE, RESP)
  - STRB_FULL = 4'hF
  - DATA_W = 32
  - DEFAULT_DEPTH_WORDS = 2048
- Sub-module rr_arbiter:
  - parameter NUM_REQ
  - inputs: request vector, pointer
  - output: one-hot grant, purely combinational
- dmem_arbiter instantiates rr_arbiter and owns the FSM, payload latches, merge and response logic.

Test Plan:
- Reset check: with i_reset = 1 and all requesters valid → all outputs 0. After release, the first grant goes to req 0.
- Full write then read:
  - req0 write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF → o_mem_wren pulses in cycle 1; rsp_valid[0] in cycle 2.
  - req0 read addr 0x10 → rsp_rdata = 0xDEADBEEF in cycle 2.
- Partial RMW:
  - Memory holds 0x11223344; write wdata 0x000000AA, wstrb 0x1 → memory becomes 0x112233AA.
  - o_mem_wren appears only in MERGE; response arrives at cycle 3.
- Contention: req0 and req1 both hold valid for 4 transactions → grants alternate 0,1,0,1. Neither requester is starved.
- Reset mid-RMW: assert i_reset during MERGE → no o_mem_wren, no rsp_valid, memory word unchanged.
- Bounds, with DMEM_ARBITER_BOUNDS_EN defined:
  - read addr 0x2002 → rsp_err = 1, rdata = 0, no memory access.
  - read addr 0x2000 (word 2048) → rsp_err = 1.
  - read addr 0x1FFC → rsp_err = 0.
